// File: rtl/tick_sequencer.sv
// tick_sequencer: run controller issuing rate-divided Enable pulses with optional run length
module tick_sequencer #(
  parameter int CLOCK_FREQUENCY = 500,
  parameter int CNT_W = 4
) (
  input  logic             ClockIn,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Pause,
  input  logic [1:0]       Speed,
  input  logic [CNT_W-1:0] TickLimit,
  output logic             Enable,
  output logic [CNT_W-1:0] TickCount,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       State
);
  localparam int DW = $clog2(4 * CLOCK_FREQUENCY);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state, state_nxt, speed_q;
  logic [CNT_W-1:0] limit_q, count_inc;
  logic [DW-1:0] div;
  logic run, accept, tick, last;
  function automatic logic [DW-1:0] period_m1(input logic [1:0] s);
    return s == 2'd0 ? '0 :
           s == 2'd1 ? DW'(CLOCK_FREQUENCY - 1) :
           s == 2'd2 ? DW'(2 * CLOCK_FREQUENCY - 1) : DW'(4 * CLOCK_FREQUENCY - 1);
  endfunction
  always_comb begin
    run = state == RUN;
    accept = !run && Start && !Stop;
    tick = run && !Stop && !Pause && div == '0;
    count_inc = TickCount + CNT_W'(1);
    last = tick && limit_q != '0 && count_inc == limit_q;
  end
  always_ff @(posedge ClockIn)
    if (Reset) state <= IDLE;
    else state <= state_nxt;
  // state 3 is never produced and falls back to IDLE
  always_comb begin
    state_nxt = run ? (Stop ? IDLE : last ? DONE : RUN) :
                accept ? RUN :
                (state == DONE && !Stop) ? DONE : IDLE;
  end
  always_comb begin
    Busy = run;
    State = state;
  end
  always_ff @(posedge ClockIn)
    if (Reset) begin
      Enable <= 1'b0;
      Done <= 1'b0;
      TickCount <= '0;
      div <= '0;
      speed_q <= '0;
      limit_q <= '0;
    end else begin
      Enable <= tick;
      Done <= last;
      if (accept) begin
        speed_q <= Speed;
        limit_q <= TickLimit;
        div <= period_m1(Speed);
        TickCount <= '0;
      end else if (run && !Stop && !Pause) begin
        div <= div == '0 ? period_m1(speed_q) : div - DW'(1);
        if (tick) TickCount <= count_inc;
      end
    end
endmodule

// File: tb/tb_tick_sequencer.sv
// tb_tick_sequencer: directed checks of run control, rate division, pause, stop and wrap
module tb_tick_sequencer;
  logic clk = 1'b0, rst, start, stop, pause;
  logic [1:0] speed, state;
  logic [3:0] limit, count;
  logic enable, busy, done;
  int pass = 0, total = 0;

  tick_sequencer #(.CLOCK_FREQUENCY(4), .CNT_W(4)) dut (
    .ClockIn(clk), .Reset(rst), .Start(start), .Stop(stop), .Pause(pause),
    .Speed(speed), .TickLimit(limit), .Enable(enable), .TickCount(count),
    .Busy(busy), .Done(done), .State(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run(input logic [1:0] s, input logic [3:0] l);
    start = 1'b1; speed = s; limit = l;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; stop = 0; pause = 0; speed = 0; limit = 0;
    step(); step();
    rst = 1'b0;
    begin_run(2'd0, 4'd0);
    step(); step(); step();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    total++; if (state !== 2'd0) $display("FAIL reset_state got %0d want 0", state); else pass++;
    total++; if (enable !== 1'b0) $display("FAIL reset_enable got %b want 0", enable); else pass++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass++;
    total++; if (count !== 4'd0) $display("FAIL reset_count got %0d want 0", count); else pass++;
  endtask

  task automatic test_limit_fast();
    begin_run(2'd0, 4'd3);
    total++; if (busy !== 1'b1 || state !== 2'd1) $display("FAIL fast_start busy %b state %0d want 1 1", busy, state); else pass++;
    for (int k = 1; k <= 5; k++) begin
      step();
      total++; if (enable !== (k <= 3)) $display("FAIL fast_enable k=%0d got %b want %b", k, enable, k <= 3); else pass++;
      total++; if (done !== (k == 3)) $display("FAIL fast_done k=%0d got %b want %b", k, done, k == 3); else pass++;
    end
    total++; if (state !== 2'd2 || count !== 4'd3 || busy !== 1'b0) $display("FAIL fast_final state %0d count %0d busy %b want 2 3 0", state, count, busy); else pass++;
  endtask

  task automatic test_speeds();
    begin_run(2'd1, 4'd2);
    for (int k = 1; k <= 10; k++) begin
      step();
      total++; if (enable !== (k == 4 || k == 8)) $display("FAIL s1_enable k=%0d got %b", k, enable); else pass++;
      total++; if (done !== (k == 8)) $display("FAIL s1_done k=%0d got %b", k, done); else pass++;
    end
    begin_run(2'd3, 4'd1);
    for (int k = 1; k <= 18; k++) begin
      step();
      total++; if (enable !== (k == 16) || done !== (k == 16)) $display("FAIL s3_pulse k=%0d enable %b done %b want %b", k, enable, done, k == 16); else pass++;
    end
    total++; if (state !== 2'd2 || count !== 4'd1) $display("FAIL s3_final state %0d count %0d want 2 1", state, count); else pass++;
  endtask

  task automatic test_pause();
    begin_run(2'd1, 4'd0);
    for (int k = 1; k <= 12; k++) begin
      step();
      total++; if (enable !== (k == 7 || k == 11)) $display("FAIL pause_enable k=%0d got %b want %b", k, enable, k == 7 || k == 11); else pass++;
      pause = (k >= 2 && k <= 4);
    end
    total++; if (count !== 4'd2) $display("FAIL pause_count got %0d want 2", count); else pass++;
    stop = 1'b1; step(); stop = 1'b0;
    total++; if (state !== 2'd0) $display("FAIL pause_stop state %0d want 0", state); else pass++;
  endtask

  task automatic test_stop();
    begin_run(2'd0, 4'd0);
    for (int k = 1; k <= 5; k++) step();
    stop = 1'b1; step(); stop = 1'b0;
    total++; if (state !== 2'd0 || count !== 4'd5 || enable !== 1'b0) $display("FAIL stop_run state %0d count %0d enable %b want 0 5 0", state, count, enable); else pass++;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (enable !== 1'b0 || count !== 4'd5) $display("FAIL stop_hold enable %b count %0d want 0 5", enable, count); else pass++;
    end
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    total++; if (state !== 2'd0 || count !== 4'd5) $display("FAIL start_stop state %0d count %0d want 0 5", state, count); else pass++;
    begin_run(2'd0, 4'd0);
    step(); step();
    start = 1'b1; step(); start = 1'b0;
    total++; if (count !== 4'd3 || state !== 2'd1) $display("FAIL start_in_run count %0d state %0d want 3 1", count, state); else pass++;
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic test_wrap();
    logic seen_done = 1'b0;
    begin_run(2'd0, 4'd0);
    for (int k = 1; k <= 16; k++) begin
      step();
      seen_done |= done;
      if (k == 15) begin
        total++; if (count !== 4'd15) $display("FAIL wrap_15 got %0d want 15", count); else pass++;
      end
    end
    total++; if (count !== 4'd0 || state !== 2'd1) $display("FAIL wrap_0 count %0d state %0d want 0 1", count, state); else pass++;
    total++; if (seen_done !== 1'b0) $display("FAIL wrap_done got %b want 0", seen_done); else pass++;
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_limit_fast();
    test_speeds();
    test_pause();
    test_stop();
    test_wrap();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
